// File: rtl/cache_pkg.sv
// Shared types and constants for the direct-mapped data cache miss controller.
package cache_pkg;
    localparam int LINE_WIDTH  = 128;
    localparam int OFFSET_BITS = 4;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        REFILL,
        FILL
    } cache_state_t;
endpackage

// File: rtl/cache_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);
    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/cache_ctrl.sv
// Miss handler for the 2-line direct-mapped cache: stalls the CPU, writes back
// dirty victims, refills the line and counts hits, misses and write-backs.
module cache_ctrl
    import cache_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WIDTH = cache_pkg::LINE_WIDTH,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_rd_en,
    input  logic                  cpu_wr_en,
    input  logic [DATA_WIDTH-1:0] cpu_addr,
    output logic                  stall,
    input  logic                  lookup_hit,
    input  logic                  victim_dirty,
    input  logic [LINE_WIDTH-1:0] victim_data,
    input  logic [DATA_WIDTH-1:0] victim_addr,
    output logic                  cache_rd_en,
    output logic                  cache_wr_en,
    output logic                  fill_en,
    output logic [LINE_WIDTH-1:0] fill_data,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic [CNT_WIDTH-1:0]  hit_cnt,
    output logic [CNT_WIDTH-1:0]  miss_cnt,
    output logic [CNT_WIDTH-1:0]  wb_cnt
);
    cache_state_t          state_q;
    logic                  mem_req_q;
    logic                  mem_we_q;
    logic                  fill_en_q;
    logic [DATA_WIDTH-1:0] mem_addr_q;
    logic [LINE_WIDTH-1:0] mem_wdata_q;
    logic [LINE_WIDTH-1:0] fill_data_q;

    logic                  access;
    logic                  in_idle;
    logic                  hit_inc;
    logic                  miss_inc;
    logic                  wb_inc;
    logic [DATA_WIDTH-1:0] refill_addr;
    logic [DATA_WIDTH-1:0] victim_line_addr;
    logic                  unused_offset_bits;

    assign access           = cpu_rd_en || cpu_wr_en;
    assign in_idle          = (state_q == IDLE);
    assign hit_inc          = in_idle && access && lookup_hit;
    assign miss_inc         = in_idle && access && !lookup_hit;
    assign wb_inc           = (state_q == WRITEBACK) && mem_ack;
    assign refill_addr      = {cpu_addr[DATA_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
    assign victim_line_addr = {victim_addr[DATA_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
    assign unused_offset_bits = ^{cpu_addr[OFFSET_BITS-1:0], victim_addr[OFFSET_BITS-1:0]};

    // A miss stalls in the same cycle it is seen, before the FSM has moved.
    assign stall       = !in_idle || miss_inc;
    assign cache_wr_en = hit_inc && cpu_wr_en;
    assign cache_rd_en = hit_inc && cpu_rd_en && !cpu_wr_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            fill_en_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            fill_data_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (miss_inc) begin
                        mem_req_q <= 1'b1;
                        if (victim_dirty) begin
                            state_q     <= WRITEBACK;
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= victim_line_addr;
                            mem_wdata_q <= victim_data;
                        end else begin
                            state_q    <= REFILL;
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= refill_addr;
                        end
                    end
                end
                // Request stays up across the hand-over; only direction and address change.
                WRITEBACK: begin
                    if (mem_ack) begin
                        state_q    <= REFILL;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= refill_addr;
                    end
                end
                REFILL: begin
                    if (mem_ack) begin
                        state_q     <= FILL;
                        mem_req_q   <= 1'b0;
                        fill_data_q <= mem_rdata;
                        fill_en_q   <= 1'b1;
                    end
                end
                FILL: begin
                    state_q   <= IDLE;
                    fill_en_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign fill_en   = fill_en_q;
    assign fill_data = fill_data_q;

    sat_counter #(.WIDTH(CNT_WIDTH)) u_hit_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (hit_inc),
        .count(hit_cnt)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (miss_inc),
        .count(miss_cnt)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_wb_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (wb_inc),
        .count(wb_cnt)
    );
endmodule

// File: tb/tb_cache_ctrl.sv
// Scoreboard bench for cache_ctrl: a cache/memory environment drives the DUT,
// an abstract cache model predicts memory traffic, fills, hits and counters.
module tb_cache_ctrl;
    localparam int DW = 32;
    localparam int LW = 128;
    localparam int CW = 6;
    localparam logic [CW-1:0] CMAX = '1;
    localparam int CMAX_I = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cpu_rd_en, cpu_wr_en;
    logic [DW-1:0] cpu_addr;
    logic          stall;
    logic          lookup_hit, victim_dirty;
    logic [LW-1:0] victim_data;
    logic [DW-1:0] victim_addr;
    logic          cache_rd_en, cache_wr_en, fill_en;
    logic [LW-1:0] fill_data;
    logic          mem_req, mem_we;
    logic [DW-1:0] mem_addr;
    logic [LW-1:0] mem_wdata, mem_rdata;
    logic          mem_ack;
    logic [CW-1:0] hit_cnt, miss_cnt, wb_cnt;

    always #5 clk = ~clk;

    cache_ctrl #(.DATA_WIDTH(DW), .LINE_WIDTH(LW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_rd_en(cpu_rd_en), .cpu_wr_en(cpu_wr_en), .cpu_addr(cpu_addr), .stall(stall),
        .lookup_hit(lookup_hit), .victim_dirty(victim_dirty),
        .victim_data(victim_data), .victim_addr(victim_addr),
        .cache_rd_en(cache_rd_en), .cache_wr_en(cache_wr_en),
        .fill_en(fill_en), .fill_data(fill_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [LW-1:0] init_line(input logic [31:0] a);
        return {a ^ 32'hC0DE_0000, a + 32'd3, a + 32'd2, a + 32'd1};
    endfunction

    // Environment: cache arrays and main memory as seen by the controller.
    logic          tb_init;
    logic          env_valid [2];
    logic          env_dirty [2];
    logic [26:0]   env_tag   [2];
    logic [LW-1:0] env_line  [2];
    logic [LW-1:0] env_mem   [64];
    logic          env_idx;
    logic [31:0]   st_data;
    int            mem_delay;
    int            mem_cnt;

    always_comb begin
        env_idx      = cpu_addr[4];
        lookup_hit   = env_valid[env_idx] && (env_tag[env_idx] == cpu_addr[31:5]);
        victim_dirty = env_valid[env_idx] && env_dirty[env_idx];
        victim_data  = env_line[env_idx];
        victim_addr  = {env_tag[env_idx], env_idx, 4'b0};
    end

    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < 2; i++) begin
                env_valid[i] <= 1'b0;
                env_dirty[i] <= 1'b0;
                env_tag[i]   <= '0;
                env_line[i]  <= '0;
            end
            for (int i = 0; i < 64; i++) env_mem[i] <= init_line(32'(i) << 4);
        end else begin
            if (fill_en) begin
                env_line[cpu_addr[4]]  <= fill_data;
                env_tag[cpu_addr[4]]   <= cpu_addr[31:5];
                env_valid[cpu_addr[4]] <= 1'b1;
                env_dirty[cpu_addr[4]] <= 1'b0;
            end
            if (cache_wr_en) begin
                env_line[cpu_addr[4]][cpu_addr[3:2]*32 +: 32] <= st_data;
                env_dirty[cpu_addr[4]] <= 1'b1;
            end
            if (mem_req && mem_ack && mem_we) env_mem[mem_addr[9:4]] <= mem_wdata;
        end
    end

    // Memory responder: acks mem_delay cycles after each request starts.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        mem_cnt   = 0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req) begin
                if (mem_cnt >= mem_delay) begin
                    mem_ack = 1'b1;
                    mem_cnt = 0;
                end else begin
                    mem_ack = 1'b0;
                    mem_cnt++;
                end
            end else begin
                mem_ack = 1'b0;
                mem_cnt = 0;
            end
            mem_rdata = env_mem[mem_addr[9:4]];
        end
    end

    // Scoreboard
    typedef enum int {EV_WB, EV_RD, EV_FILL, EV_HIT} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        logic [31:0] addr;
        logic [LW-1:0] data;
        logic        wr;
    } ev_t;
    ev_t exp_q[$];

    task automatic push_ev(input ev_kind_t k, input logic [31:0] a, input logic [LW-1:0] d, input logic w);
        ev_t e;
        e.kind = k; e.addr = a; e.data = d; e.wr = w;
        exp_q.push_back(e);
    endtask

    task automatic pop_ev(input string name, output ev_t e, output bit ok);
        ok = (exp_q.size() != 0);
        if (ok) begin
            e = exp_q.pop_front();
        end else begin
            vectors++;
            miscompares++;
            e.kind = EV_HIT; e.addr = '0; e.data = '0; e.wr = 1'b0;
            $display("FAIL %s: got unexpected DUT event, required none at %0t", name, $time);
        end
    endtask

    logic          mon_en;
    logic          txn_act;
    logic          txn_we;
    logic [31:0]   txn_addr;
    logic [LW-1:0] txn_wd;

    initial begin
        ev_t e;
        bit ok;
        txn_act = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && mon_en) begin
                if (mem_req) begin
                    check("stall_during_mem", stall, 1);
                    check("cache_en_during_mem", {cache_rd_en, cache_wr_en}, 0);
                    if (txn_act) begin
                        check("mem_we_stable", mem_we, txn_we);
                        check("mem_addr_stable", mem_addr, txn_addr);
                        check("mem_wdata_stable", mem_wdata, txn_wd);
                    end else begin
                        txn_act  = 1'b1;
                        txn_we   = mem_we;
                        txn_addr = mem_addr;
                        txn_wd   = mem_wdata;
                    end
                    if (mem_ack) begin
                        txn_act = 1'b0;
                        pop_ev("mem_txn", e, ok);
                        if (ok) begin
                            check("mem_we", mem_we, (e.kind == EV_WB));
                            check("mem_addr", mem_addr, e.addr);
                            if (e.kind == EV_WB) check("wb_data", mem_wdata, e.data);
                        end
                    end
                end else begin
                    txn_act = 1'b0;
                end
                if (fill_en) begin
                    check("stall_during_fill", stall, 1);
                    pop_ev("fill", e, ok);
                    if (ok) begin
                        check("fill_kind", (e.kind == EV_FILL), 1);
                        check("fill_data", fill_data, e.data);
                    end
                end
                if ((cpu_rd_en || cpu_wr_en) && !stall) begin
                    pop_ev("hit", e, ok);
                    if (ok) begin
                        check("hit_kind", (e.kind == EV_HIT), 1);
                        check("cache_wr_en", cache_wr_en, e.wr);
                        check("cache_rd_en", cache_rd_en, !e.wr);
                    end
                end
            end else begin
                txn_act = 1'b0;
            end
        end
    end

    // Reference model: abstract cache contents, memory image and counters.
    logic          ref_valid [2];
    logic          ref_dirty [2];
    logic [26:0]   ref_tag   [2];
    logic [LW-1:0] ref_line  [2];
    logic [LW-1:0] ref_mem   [64];
    int            ref_hit, ref_miss, ref_wb;

    function automatic int sat_inc(input int v);
        return (v >= CMAX_I) ? CMAX_I : v + 1;
    endfunction

    task automatic check_counters();
        check("hit_cnt", hit_cnt, ref_hit);
        check("miss_cnt", miss_cnt, ref_miss);
        check("wb_cnt", wb_cnt, ref_wb);
    endtask

    task automatic do_access(input bit rd, input bit wr, input logic [31:0] addr, input int k);
        logic        idx;
        logic [31:0] laddr, vaddr;
        logic [31:0] wdat;
        int          exp_cyc, cyc;
        idx   = addr[4];
        laddr = {addr[31:4], 4'b0};
        wdat  = $urandom;
        if (ref_valid[idx] && ref_tag[idx] == addr[31:5]) begin
            exp_cyc = 0;
        end else begin
            ref_miss = sat_inc(ref_miss);
            if (ref_valid[idx] && ref_dirty[idx]) begin
                vaddr = {ref_tag[idx], idx, 4'b0};
                push_ev(EV_WB, vaddr, ref_line[idx], 1'b1);
                ref_mem[vaddr[9:4]] = ref_line[idx];
                ref_wb  = sat_inc(ref_wb);
                exp_cyc = 4 + 2 * k;
            end else begin
                exp_cyc = 3 + k;
            end
            push_ev(EV_RD, laddr, '0, 1'b0);
            push_ev(EV_FILL, laddr, ref_mem[laddr[9:4]], 1'b0);
            ref_line[idx]  = ref_mem[laddr[9:4]];
            ref_tag[idx]   = addr[31:5];
            ref_valid[idx] = 1'b1;
            ref_dirty[idx] = 1'b0;
        end
        ref_hit = sat_inc(ref_hit);
        push_ev(EV_HIT, addr, '0, wr);
        if (wr) begin
            ref_line[idx][addr[3:2]*32 +: 32] = wdat;
            ref_dirty[idx] = 1'b1;
        end

        @(posedge clk);
        #1;
        mem_delay = k;
        st_data   = wdat;
        cpu_addr  = addr;
        cpu_rd_en = rd;
        cpu_wr_en = wr;
        cyc = 0;
        forever begin
            @(negedge clk);
            if (!stall) break;
            cyc++;
            if (cyc > 200) break;
        end
        check("access_latency", cyc, exp_cyc);
        if (cyc > 200) exp_q.delete();
        @(posedge clk);
        #1;
        cpu_rd_en = 1'b0;
        cpu_wr_en = 1'b0;
        check_counters();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, required $finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          w;
        logic [31:0] a;
        rst_n     = 1'b0;
        tb_init   = 1'b1;
        mon_en    = 1'b0;
        cpu_rd_en = 1'b0;
        cpu_wr_en = 1'b0;
        cpu_addr  = 32'h100;
        st_data   = '0;
        mem_delay = 0;
        for (int i = 0; i < 2; i++) begin
            ref_valid[i] = 1'b0;
            ref_dirty[i] = 1'b0;
            ref_tag[i]   = '0;
            ref_line[i]  = '0;
        end
        for (int i = 0; i < 64; i++) ref_mem[i] = init_line(32'(i) << 4);
        ref_hit = 0; ref_miss = 0; ref_wb = 0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_stall_idle", stall, 0);
        check("rst_cache_en", {cache_rd_en, cache_wr_en}, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_fill_en", fill_en, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_fill_data", fill_data, 0);
        check_counters();
        cpu_rd_en = 1'b1;
        #1;
        check("rst_stall_on_miss", stall, 1);
        check("rst_rd_en_on_miss", cache_rd_en, 0);
        cpu_rd_en = 1'b0;
        tb_init   = 1'b0;
        @(posedge clk);
        #3;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Abandon a refill with an asynchronous reset, then restart.
        @(posedge clk);
        #1;
        mem_delay = 20;
        cpu_addr  = 32'h200;
        cpu_rd_en = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("req_before_reset", mem_req, 1);
        check("miss_before_reset", miss_cnt, 1);
        rst_n = 1'b0;
        #1;
        check("req_async_drop", mem_req, 0);
        check_counters();
        cpu_rd_en = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #3;
        rst_n = 1'b1;

        do_access(1'b1, 1'b0, 32'h100, 1);
        do_access(1'b0, 1'b1, 32'h108, 0);
        do_access(1'b1, 1'b0, 32'h120, 0);
        do_access(1'b0, 1'b1, 32'h014, 2);
        do_access(1'b1, 1'b1, 32'h12C, 3);
        do_access(1'b1, 1'b0, 32'h100, 5);

        for (int n = 0; n < 150; n++) begin
            w = 1'($urandom_range(0, 1));
            a = 32'h100 + (32'($urandom_range(0, 7)) << 4) + (32'($urandom_range(0, 3)) << 2);
            do_access(!w || ($urandom_range(0, 3) == 0), w, a, $urandom_range(0, 4));
        end

        for (int n = 0; n < 70; n++) do_access(1'b1, 1'b0, 32'h100, 0);
        check("hit_cnt_saturated", hit_cnt, CMAX);

        repeat (2) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
